// File: rtl/down_counter_pkg.sv
// Shared definitions for the down-counter block: FSM state encoding and default width.
package down_counter_pkg;

  localparam int unsigned WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_3bit.sv
// Loadable down-counter with IDLE/RUN/DONE control, one-shot or periodic reload,
// and a registered one-cycle borrow pulse on each terminal count.
module down_counter_3bit
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             borrow,
  output logic             done,
  output logic             busy
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] reload_q;
  logic             at_zero;
  logic             tc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Load outranks both decrement and terminal-count handling, so tc is masked by it.
  always_comb begin
    at_zero = (count == '0);
    tc      = (state == RUN) && en && at_zero && !load;
    state_n = state;
    if (load) begin
      if (start) begin
        state_n = RUN;
      end else if (state == DONE) begin
        state_n = IDLE;
      end
    end else begin
      unique case (state)
        IDLE: if (start) state_n = RUN;
        RUN:  if (en && at_zero && !auto_reload) state_n = DONE;
        DONE: if (start) state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '1;
      reload_q <= '1;
      borrow   <= 1'b0;
    end else begin
      borrow <= tc;
      if (load) begin
        count    <= load_val;
        reload_q <= load_val;
      end else begin
        unique case (state)
          RUN: begin
            if (en) begin
              if (!at_zero) begin
                count <= count - WIDTH'(1);
              end else if (auto_reload) begin
                count <= reload_q;
              end
            end
          end
          DONE: if (start) count <= reload_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_counter_3bit.sv
// Directed bench for down_counter_3bit: a behavioural model checked every cycle,
// plus literal expectations pinned at chosen points of the sequence.
module tb_down_counter_3bit;

  localparam int W    = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         borrow;
  logic         done;
  logic         busy;

  down_counter_3bit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .start(start), .auto_reload(auto_reload), .count(count), .borrow(borrow),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = waiting, 1 = counting, 2 = finished.
  int m_cnt = 0, m_rel = 0, m_ph = 0;
  int m_bor = 0;
  int nc, nr, np, nb;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = MAXV; m_rel = MAXV; m_ph = 0; m_bor = 0;
    end else begin
      nc = m_cnt; nr = m_rel; np = m_ph; nb = 0;
      if (load) begin
        nc = int'(load_val); nr = int'(load_val);
        if (start) np = 1;
        else if (m_ph == 2) np = 0;
      end else if (m_ph == 0) begin
        if (start) np = 1;
      end else if (m_ph == 1) begin
        if (en) begin
          if (m_cnt > 0) nc = (m_cnt - 1) % (MAXV + 1);
          else begin
            nb = 1;
            if (auto_reload) nc = m_rel;
            else np = 2;
          end
        end
      end else if (start) begin
        nc = m_rel; np = 1;
      end
      m_cnt = nc; m_rel = nr; m_ph = np; m_bor = nb;
    end
  end

  int n_cmp = 0, n_err = 0;
  bit pin_valid = 0;
  int p_cnt, p_bor, p_busy, p_done;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_count", int'(count), m_cnt);
    check("model_borrow", int'(borrow), m_bor);
    check("model_busy", int'(busy), int'(m_ph == 1));
    check("model_done", int'(done), int'(m_ph == 2));
    if (pin_valid) begin
      check("pin_count", int'(count), p_cnt);
      check("pin_borrow", int'(borrow), p_bor);
      check("pin_busy", int'(busy), p_busy);
      check("pin_done", int'(done), p_done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input int c, input int b, input int bs, input int dn);
    p_cnt = c; p_bor = b; p_busy = bs; p_done = dn;
    pin_valid = 1;
    @(negedge clk);
    #1 pin_valid = 0;
  endtask

  initial begin
    #1 reset = 1'b0;
    pin(7, 0, 0, 0);
    reset = 1'b1;
    step(); pin(7, 0, 0, 0);

    // One-shot run from reset value down to terminal count.
    start = 1; en = 1; auto_reload = 0;
    step(); start = 0; pin(7, 0, 1, 0);
    for (int i = 6; i >= 0; i--) begin
      step(); pin(i, 0, 1, 0);
    end
    step(); pin(0, 1, 0, 1);
    step(); pin(0, 0, 0, 1);

    // Load in DONE returns to IDLE; start resumes from loaded value.
    load = 1; load_val = 3'd4;
    step(); load = 0; pin(4, 0, 0, 0);
    start = 1;
    step(); start = 0; pin(4, 0, 1, 0);
    step(); pin(3, 0, 1, 0);

    // Load in RUN keeps RUN; then en gating.
    load = 1; load_val = 3'd6;
    step(); load = 0; pin(6, 0, 1, 0);
    step(); pin(5, 0, 1, 0);
    en = 1; step(); pin(4, 0, 1, 0);
    en = 0; step(); pin(4, 0, 1, 0);
    en = 1; step(); pin(3, 0, 1, 0);

    // Asynchronous reset mid-run aborts without borrow.
    #2 reset = 1'b0;
    pin(7, 0, 0, 0);
    reset = 1'b1;
    step(); pin(7, 0, 0, 0);

    // Periodic mode with reload value 2.
    load = 1; load_val = 3'd2; auto_reload = 1; start = 1; en = 1;
    step(); load = 0; start = 0; pin(2, 0, 1, 0);
    step(); pin(1, 0, 1, 0);
    step(); pin(0, 0, 1, 0);
    step(); pin(2, 1, 1, 0);
    step(); pin(1, 0, 1, 0);
    step(); pin(0, 0, 1, 0);
    step(); pin(2, 1, 1, 0);
    step(); pin(1, 0, 1, 0);
    step(); pin(0, 0, 1, 0);

    // Load at terminal count wins and suppresses borrow.
    load = 1; load_val = 3'd6;
    step(); pin(6, 0, 1, 0);

    // Reload value zero in periodic mode: borrow every enabled cycle.
    load_val = 3'd0;
    step(); load = 0; pin(0, 0, 1, 0);
    step(); pin(0, 1, 1, 0);
    step(); pin(0, 1, 1, 0);

    // Start in RUN is ignored.
    en = 0; start = 1;
    step(); start = 0; pin(0, 0, 1, 0);

    // One-shot terminal, then load+start from DONE.
    en = 1; auto_reload = 0;
    step(); pin(0, 1, 0, 1);
    load = 1; start = 1; load_val = 3'd5;
    step(); load = 0; start = 0; pin(5, 0, 1, 0);
    for (int i = 4; i >= 0; i--) begin
      step(); pin(i, 0, 1, 0);
    end
    step(); pin(0, 1, 0, 1);
    en = 0; start = 1;
    step(); start = 0; pin(5, 0, 1, 0);

    // Mixed stimulus, checked by the model alone.
    for (int i = 0; i < 300; i++) begin
      load        = ($urandom_range(0, 9) == 0);
      start       = ($urandom_range(0, 5) == 0);
      en          = ($urandom_range(0, 3) != 0);
      auto_reload = 1'($urandom_range(0, 1));
      load_val    = W'($urandom_range(0, MAXV));
      step();
    end
    load = 0; start = 0; en = 0;
    step();
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/down_counter_3bit.md
DOWN_COUNTER_3BIT -- requirements
Module: down_counter_3bit

Interface
REQ-001 SHALL have parameter WIDTH, default 3, counter width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  decrement enable, honoured only in RUN.
REQ-005 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-006 SHALL have port load_val  input  WIDTH  value for count and reload register on load.
REQ-007 SHALL have port start  input  1  start/restart request.
REQ-008 SHALL have port auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at each terminal count.
REQ-009 SHALL have port count  output  WIDTH  current counter value, registered.
REQ-010 SHALL have port borrow  output  1  one-cycle pulse on each terminal-count event.
REQ-011 SHALL have port done  output  1  high while in DONE state.
REQ-012 SHALL have port busy  output  1  high while in RUN state.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both decoded from the state register.
REQ-014 IDLE: count holds; start=1 -> RUN at next edge; count unchanged on that edge.
REQ-015 RUN, en=1, count>0: count <= count-1 each edge.
REQ-016 RUN, en=1, count==0, auto_reload=1: count <= reload register, borrow=1 for that cycle, stay in RUN.
REQ-017 RUN, en=1, count==0, auto_reload=0: count stays 0, borrow=1 for that cycle, next state DONE.
REQ-018 RUN, en=0: count and state hold; borrow=0.
REQ-019 DONE: count holds at 0; start=1 -> count <= reload register, next state RUN.
REQ-020 load=1 in any state: count <= load_val and reload register <= load_val on that edge; load has priority over decrement and over reload.
REQ-021 load=1 in DONE without start: next state IDLE; load in IDLE or RUN does not change state.
REQ-022 load=1 and start=1 together: load_val taken; next state RUN from any state.
REQ-023 start=1 in RUN: ignored.
REQ-024 borrow SHALL be registered, asserted for exactly one cycle per terminal-count event, and never asserted on a load edge.
REQ-025 Decrement SHALL be modulo 2^WIDTH with no other wrap path; count never exceeds 2^WIDTH-1.
REQ-026 load_val=0 in periodic mode: borrow every enabled cycle, count stays 0.

Reset
REQ-027 reset low SHALL immediately set count = all ones (3'b111 at WIDTH=3), reload register = all ones, state IDLE, borrow=0.
REQ-028 reset asserted mid-RUN SHALL abort the count with no borrow pulse; after release the block waits in IDLE for start.
REQ-029 Release of reset SHALL take effect at the first rising clk edge after deassertion; no output glitches during assertion.

Structure
REQ-030 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default constant in shared package down_counter_pkg.
REQ-031 SHALL be a single module with no sub-module; FSM, count register, reload register and borrow register coexist in one file, 120-400 lines.

Verification
REQ-032 reset low, then high; start=1 one cycle, en=1 -> count 7,6,5,...,0 on successive edges after the RUN entry edge; auto_reload=0 -> borrow one pulse, done=1, count holds 0.
REQ-033 load=1, load_val=3'b010, auto_reload=1, start, en=1 -> count 2,1,0,2,1,0,...; borrow pulses every third enabled cycle; busy stays 1.
REQ-034 In RUN at count=5, en toggled 1,0,1 -> count 4,4,3; no borrow.
REQ-035 In DONE, load=1, load_val=3'b100 -> count=4, state IDLE (done=0, busy=0); subsequent start -> RUN from 4.
REQ-036 At count=0 in RUN with en=1, assert load=1, load_val=3'b110 the same cycle -> count=6, no borrow, state RUN.
REQ-037 reset pulsed low mid-RUN at count=3 -> count=7 immediately, borrow=0, busy=0; no activity until start.
